// File: rtl/rc5_pkg.sv
// ----------------------------------------------------------------------------
// rc5_pkg
//
// Shared definitions for the RC5 block cipher datapath:
//   - default word width (W), round count (R) and S-table depth (T)
//   - FSM state encoding used by rc5_encryptor
//   - RC5 magic constants P32 / Q32 used by the key schedule that builds S[]
//
// Optional feature macro used elsewhere in this slice: RC5_DECRYPT_EN
// ----------------------------------------------------------------------------
package rc5_pkg;

    localparam int W_DEFAULT = 32;
    localparam int R_DEFAULT = 12;
    localparam int T_DEFAULT = 2 * R_DEFAULT + 2;

    // Magic constants from the RC5 key schedule (odd((e-2)*2^32), odd((phi-1)*2^32))
    localparam logic [31:0] P32 = 32'hB7E15163;
    localparam logic [31:0] Q32 = 32'h9E3779B9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_S = 2'd1,
        MIX    = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/rc5_rotate.sv
// ----------------------------------------------------------------------------
// rc5_rotate
//
// Combinational variable rotate of one W-bit word.
//
// Ports:
//   data      in  [W-1:0]          word to rotate
//   amount    in  [$clog2(W)-1:0]  rotate distance (only low log2(W) bits exist)
//   direction in  1                0 = rotate left, 1 = rotate right
//   result    out [W-1:0]          rotated word
//
// W is expected to be a power of two so that the amount field covers every
// distance exactly once.
// ----------------------------------------------------------------------------
module rc5_rotate #(
    parameter int W = 32
) (
    input  logic [W-1:0]         data,
    input  logic [$clog2(W)-1:0] amount,
    input  logic                 direction,
    output logic [W-1:0]         result
);

    logic [2*W-1:0] left_full;
    logic [2*W-1:0] right_full;

    // Shifting a doubled copy of the word turns the rotate into a plain shift:
    // the top half of a left shift, or the bottom half of a right shift, is
    // exactly the rotated word.
    always_comb begin
        left_full  = {data, data} << amount;
        right_full = {data, data} >> amount;
        result     = direction ? right_full[W-1:0] : left_full[2*W-1:W];
    end

endmodule

// File: rtl/rc5_encryptor.sv
// ----------------------------------------------------------------------------
// rc5_encryptor
//
// Iterative RC5-W/R block encryptor. One S-table word is consumed every two
// cycles: a WAIT_S cycle presents the address to an external S-table with one
// cycle of read latency, and the following MIX cycle folds that word into A or
// B. A full block takes 2T+1 cycles from start acceptance to the oDone pulse.
//
// Ports:
//   clk         in   1            clock, rising edge
//   rst         in   1            asynchronous active-high reset
//   iStart      in   1            start request, only looked at in IDLE
//   iPlainA/B   in   [W-1:0]      plaintext words, captured on accepted start
//   iDecrypt    in   1            (RC5_DECRYPT_EN only) 1 = decrypt, captured at start
//   oS_address  out  [clog2(T)]   S-table read address
//   iS_sub_i    in   [W-1:0]      S-table data for previous cycle's address
//   oCipherA/B  out  [W-1:0]      result words, held until the next result
//   oBusy       out  1            operation in flight
//   oDone       out  1            one-cycle result-valid pulse
//
// Optional feature macro: RC5_DECRYPT_EN adds iDecrypt and the inverse
// datapath. Without it the block is encryption only.
// ----------------------------------------------------------------------------
module rc5_encryptor
    import rc5_pkg::*;
#(
    parameter  int W = W_DEFAULT,
    parameter  int R = R_DEFAULT,
    localparam int T = 2 * R + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iStart,
    input  logic [W-1:0]         iPlainA,
    input  logic [W-1:0]         iPlainB,
`ifdef RC5_DECRYPT_EN
    input  logic                 iDecrypt,
`endif
    output logic [$clog2(T)-1:0] oS_address,
    input  logic [W-1:0]         iS_sub_i,
    output logic [W-1:0]         oCipherA,
    output logic [W-1:0]         oCipherB,
    output logic                 oBusy,
    output logic                 oDone
);

    localparam int AW = $clog2(T);
    localparam int LW = $clog2(W);

    state_t          state;
    state_t          next_state;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [AW-1:0]   k_reg;
    logic [AW-1:0]   k_first;
    logic [AW-1:0]   k_step;
    logic            last_word;
    logic            first_pair;
    logic [W-1:0]    a_mix;
    logic [W-1:0]    b_mix;
    logic [W-1:0]    rot_data;
    logic [LW-1:0]   rot_amount;
    logic            rot_dir;
    logic [W-1:0]    rot_result;
    logic [W-1:0]    cipher_a;
    logic [W-1:0]    cipher_b;
`ifdef RC5_DECRYPT_EN
    logic            decrypt_reg;
`endif

    // The word index doubles as the S-table address: it is loaded on start,
    // held through WAIT_S, and stepped on each MIX that is not the last one.
    assign oS_address = k_reg;
    assign oCipherA   = cipher_a;
    assign oCipherB   = cipher_b;

    // Word index sequencing. Encryption walks 0..T-1; decryption walks the
    // table backwards from T-1 to 0 so that the rounds unwind in reverse.
    always_comb begin
        k_first   = '0;
        k_step    = k_reg + AW'(1);
        last_word = (k_reg == AW'(T - 1));
`ifdef RC5_DECRYPT_EN
        if (iDecrypt) begin
            k_first = AW'(T - 1);
        end
        if (decrypt_reg) begin
            k_step    = k_reg - AW'(1);
            last_word = (k_reg == '0);
        end
`endif
    end

    // Feed the single shared rotator. Odd words update B and rotate by A,
    // even words update A and rotate by B, in both directions. Encryption
    // rotates A^B left; decryption rotates (word - S[k]) right.
    always_comb begin
        rot_amount = k_reg[0] ? a_reg[LW-1:0] : b_reg[LW-1:0];
        rot_data   = a_reg ^ b_reg;
        rot_dir    = 1'b0;
`ifdef RC5_DECRYPT_EN
        if (decrypt_reg) begin
            rot_dir  = 1'b1;
            rot_data = k_reg[0] ? (b_reg - iS_sub_i) : (a_reg - iS_sub_i);
        end
`endif
    end

    rc5_rotate #(
        .W(W)
    ) rotate_unit (
        .data      (rot_data),
        .amount    (rot_amount),
        .direction (rot_dir),
        .result    (rot_result)
    );

    // One update per MIX cycle. Words 0 and 1 are the pre-whitening (or, when
    // decrypting, post-whitening) additions and skip the rotate entirely.
    always_comb begin
        a_mix      = a_reg;
        b_mix      = b_reg;
        first_pair = (k_reg < AW'(2));
        if (first_pair) begin
            if (k_reg[0]) begin
                b_mix = b_reg + iS_sub_i;
            end else begin
                a_mix = a_reg + iS_sub_i;
            end
        end else if (k_reg[0]) begin
            b_mix = rot_result + iS_sub_i;
        end else begin
            a_mix = rot_result + iS_sub_i;
        end
`ifdef RC5_DECRYPT_EN
        if (decrypt_reg) begin
            a_mix = a_reg;
            b_mix = b_reg;
            if (first_pair) begin
                if (k_reg[0]) begin
                    b_mix = b_reg - iS_sub_i;
                end else begin
                    a_mix = a_reg - iS_sub_i;
                end
            end else if (k_reg[0]) begin
                b_mix = rot_result ^ a_reg;
            end else begin
                a_mix = rot_result ^ b_reg;
            end
        end
`endif
    end

    // FSM next-state and status outputs.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (iStart) next_state = WAIT_S;
            WAIT_S:  next_state = MIX;
            MIX:     next_state = last_word ? DONE : WAIT_S;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        oBusy = (state == WAIT_S) || (state == MIX);
        oDone = (state == DONE);
    end

    // State register and datapath registers. The result registers are
    // loaded with the final MIX values on the way into DONE so they are
    // already valid during the oDone cycle, and then simply hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            k_reg       <= '0;
            cipher_a    <= '0;
            cipher_b    <= '0;
`ifdef RC5_DECRYPT_EN
            decrypt_reg <= 1'b0;
`endif
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (iStart) begin
                        a_reg       <= iPlainA;
                        b_reg       <= iPlainB;
                        k_reg       <= k_first;
`ifdef RC5_DECRYPT_EN
                        decrypt_reg <= iDecrypt;
`endif
                    end
                end
                MIX: begin
                    a_reg <= a_mix;
                    b_reg <= b_mix;
                    if (last_word) begin
                        cipher_a <= a_mix;
                        cipher_b <= b_mix;
                    end else begin
                        k_reg <= k_step;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rc5_encryptor.sv
// ----------------------------------------------------------------------------
// tb_rc5_encryptor
//
// Directed bench for rc5_encryptor at W=32, R=12. Models the external S-table
// as a one-cycle-latency read port. The S-table for the known-answer vectors
// is built here from the all-zero 16-byte key using the standard RC5 key
// schedule. Decrypt scenario compiled in only with RC5_DECRYPT_EN.
// ----------------------------------------------------------------------------
module tb_rc5_encryptor;
    import rc5_pkg::*;

    localparam int W  = 32;
    localparam int R  = 12;
    localparam int T  = 2 * R + 2;
    localparam int AW = $clog2(T);

    localparam logic [31:0] KAT_A = 32'hEEDBA521;
    localparam logic [31:0] KAT_B = 32'h6D8F4B15;

    logic          clk = 1'b0;
    logic          rst;
    logic          iStart;
    logic [W-1:0]  iPlainA;
    logic [W-1:0]  iPlainB;
`ifdef RC5_DECRYPT_EN
    logic          iDecrypt;
`endif
    logic [AW-1:0] oS_address;
    logic [W-1:0]  iS_sub_i;
    logic [W-1:0]  oCipherA;
    logic [W-1:0]  oCipherB;
    logic          oBusy;
    logic          oDone;

    logic [W-1:0]  s_table [T];
    int            check_count = 0;
    int            pass_count  = 0;
    int            first_addr;

    rc5_encryptor #(
        .W(W),
        .R(R)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .iStart     (iStart),
        .iPlainA    (iPlainA),
        .iPlainB    (iPlainB),
`ifdef RC5_DECRYPT_EN
        .iDecrypt   (iDecrypt),
`endif
        .oS_address (oS_address),
        .iS_sub_i   (iS_sub_i),
        .oCipherA   (oCipherA),
        .oCipherB   (oCipherB),
        .oBusy      (oBusy),
        .oDone      (oDone)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        iS_sub_i <= s_table[oS_address];
    end

    function automatic logic [31:0] rotl32(input logic [31:0] v, input int n);
        int n5;
        n5 = n & 31;
        if (n5 == 0) return v;
        return (v << n5) | (v >> (32 - n5));
    endfunction

    task automatic clear_table();
        for (int i = 0; i < T; i++) s_table[i] = '0;
    endtask

    // Standard RC5 key schedule for a 16-byte all-zero key (L[0..3] = 0).
    task automatic build_key_table();
        logic [31:0] l [4];
        logic [31:0] x;
        logic [31:0] y;
        int          i;
        int          j;
        for (int n = 0; n < 4; n++) l[n] = '0;
        s_table[0] = P32;
        for (int n = 1; n < T; n++) s_table[n] = s_table[n-1] + Q32;
        x = '0;
        y = '0;
        i = 0;
        j = 0;
        for (int n = 0; n < 3 * T; n++) begin
            x          = rotl32(s_table[i] + x + y, 3);
            s_table[i] = x;
            y          = rotl32(l[j] + x + y, int'((x + y) & 32'd31));
            l[j]       = y;
            i          = (i + 1) % T;
            j          = (j + 1) % 4;
        end
    endtask

    // Starts one operation, scrambles the plaintext inputs after acceptance,
    // and returns at the sample point of the oDone cycle (latency -1 if none).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int latency, output int busy_cycles);
        int m;
        @(negedge clk);
        iPlainA = a;
        iPlainB = b;
        iStart  = 1'b1;
        @(negedge clk);
        iStart     = 1'b0;
        iPlainA    = ~a;
        iPlainB    = b ^ 32'h5A5AA5A5;
        first_addr = int'(oS_address);
        m           = 1;
        busy_cycles = 0;
        while (oDone !== 1'b1 && m < 100) begin
            if (oBusy === 1'b1) busy_cycles++;
            @(negedge clk);
            m++;
        end
        latency = (oDone === 1'b1) ? m : -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        check_count++;
        if (oBusy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", oBusy);
        else pass_count++;
        check_count++;
        if (oDone !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", oDone);
        else pass_count++;
        check_count++;
        if (oS_address !== '0) $display("[TB] FAIL reset_addr: got %0d expected 0", oS_address);
        else pass_count++;
        check_count++;
        if (oCipherA !== '0) $display("[TB] FAIL reset_cipher_a: got %h expected 0", oCipherA);
        else pass_count++;
        check_count++;
        if (oCipherB !== '0) $display("[TB] FAIL reset_cipher_b: got %h expected 0", oCipherB);
        else pass_count++;
        rst = 1'b0;
    endtask

    task automatic test_null_table();
        int lat;
        int busy;
        clear_table();
        run_op(32'h0, 32'h0, lat, busy);
        check_count++;
        if (lat !== 53) $display("[TB] FAIL null_latency: got %0d expected 53", lat);
        else pass_count++;
        check_count++;
        if (oCipherA !== 32'h0) $display("[TB] FAIL null_cipher_a: got %h expected 00000000", oCipherA);
        else pass_count++;
        check_count++;
        if (oCipherB !== 32'h0) $display("[TB] FAIL null_cipher_b: got %h expected 00000000", oCipherB);
        else pass_count++;
        check_count++;
        if (busy !== 52) $display("[TB] FAIL null_busy_cycles: got %0d expected 52", busy);
        else pass_count++;
        @(negedge clk);
        check_count++;
        if (oDone !== 1'b0) $display("[TB] FAIL null_done_pulse: got %b expected 0", oDone);
        else pass_count++;
    endtask

    task automatic test_known_answer();
        int lat;
        int busy;
        build_key_table();
        run_op(32'h0, 32'h0, lat, busy);
        check_count++;
        if (lat !== 53) $display("[TB] FAIL kat_latency: got %0d expected 53", lat);
        else pass_count++;
        check_count++;
        if (oCipherA !== KAT_A) $display("[TB] FAIL kat_cipher_a: got %h expected %h", oCipherA, KAT_A);
        else pass_count++;
        check_count++;
        if (oCipherB !== KAT_B) $display("[TB] FAIL kat_cipher_b: got %h expected %h", oCipherB, KAT_B);
        else pass_count++;
        repeat (3) @(negedge clk);
        check_count++;
        if (oCipherA !== KAT_A || oCipherB !== KAT_B)
            $display("[TB] FAIL kat_hold: got %h/%h expected %h/%h", oCipherA, oCipherB, KAT_A, KAT_B);
        else pass_count++;
        check_count++;
        if (oBusy !== 1'b0 || oDone !== 1'b0)
            $display("[TB] FAIL kat_idle_status: got busy=%b done=%b expected 0/0", oBusy, oDone);
        else pass_count++;
    endtask

    task automatic test_address_trace();
        @(negedge clk);
        iPlainA = 32'h0;
        iPlainB = 32'h0;
        iStart  = 1'b1;
        @(negedge clk);
        iStart  = 1'b0;
        iPlainA = 32'hDEADBEEF;
        iPlainB = 32'h01234567;
        for (int m = 1; m <= 52; m++) begin
            check_count++;
            if (oS_address !== AW'((m - 1) / 2))
                $display("[TB] FAIL trace_addr_c%0d: got %0d expected %0d", m, oS_address, (m - 1) / 2);
            else pass_count++;
            check_count++;
            if (oBusy !== 1'b1) $display("[TB] FAIL trace_busy_c%0d: got %b expected 1", m, oBusy);
            else pass_count++;
            @(negedge clk);
        end
        check_count++;
        if (oBusy !== 1'b0 || oDone !== 1'b1)
            $display("[TB] FAIL trace_end_status: got busy=%b done=%b expected 0/1", oBusy, oDone);
        else pass_count++;
        check_count++;
        if (oCipherA !== KAT_A || oCipherB !== KAT_B)
            $display("[TB] FAIL trace_cipher: got %h/%h expected %h/%h", oCipherA, oCipherB, KAT_A, KAT_B);
        else pass_count++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int lat;
        int busy;
        int done_seen;
        @(negedge clk);
        iPlainA = 32'h0;
        iPlainB = 32'h0;
        iStart  = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        #1;
        check_count++;
        if (oBusy !== 1'b0 || oDone !== 1'b0)
            $display("[TB] FAIL midrst_status: got busy=%b done=%b expected 0/0", oBusy, oDone);
        else pass_count++;
        check_count++;
        if (oS_address !== '0) $display("[TB] FAIL midrst_addr: got %0d expected 0", oS_address);
        else pass_count++;
        check_count++;
        if (oCipherA !== '0 || oCipherB !== '0)
            $display("[TB] FAIL midrst_cipher: got %h/%h expected 0/0", oCipherA, oCipherB);
        else pass_count++;
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        done_seen = 0;
        for (int m = 0; m < 60; m++) begin
            if (oDone === 1'b1 || oBusy === 1'b1) done_seen++;
            @(negedge clk);
        end
        check_count++;
        if (done_seen !== 0) $display("[TB] FAIL midrst_no_activity: got %0d active cycles expected 0", done_seen);
        else pass_count++;
        run_op(32'h0, 32'h0, lat, busy);
        check_count++;
        if (lat !== 53) $display("[TB] FAIL midrst_restart_latency: got %0d expected 53", lat);
        else pass_count++;
        check_count++;
        if (oCipherA !== KAT_A || oCipherB !== KAT_B)
            $display("[TB] FAIL midrst_restart_cipher: got %h/%h expected %h/%h", oCipherA, oCipherB, KAT_A, KAT_B);
        else pass_count++;
        @(negedge clk);
    endtask

    task automatic test_ignored_start();
        int          done_cnt;
        int          done_at;
        logic [31:0] cap_a;
        logic [31:0] cap_b;
        @(negedge clk);
        iPlainA = 32'h0;
        iPlainB = 32'h0;
        iStart  = 1'b1;
        @(negedge clk);
        iPlainA  = 32'hCAFEF00D;
        iPlainB  = 32'h8BADF00D;
        done_cnt = 0;
        done_at  = -1;
        cap_a    = '0;
        cap_b    = '0;
        for (int m = 1; m <= 60; m++) begin
            iStart = (m == 5 || m == 30);
            if (oDone === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = m;
                cap_a = oCipherA;
                cap_b = oCipherB;
            end
            @(negedge clk);
        end
        iStart = 1'b0;
        check_count++;
        if (done_cnt !== 1) $display("[TB] FAIL ignore_done_count: got %0d expected 1", done_cnt);
        else pass_count++;
        check_count++;
        if (done_at !== 53) $display("[TB] FAIL ignore_done_cycle: got %0d expected 53", done_at);
        else pass_count++;
        check_count++;
        if (cap_a !== KAT_A || cap_b !== KAT_B)
            $display("[TB] FAIL ignore_cipher: got %h/%h expected %h/%h", cap_a, cap_b, KAT_A, KAT_B);
        else pass_count++;
    endtask

    task automatic test_back_to_back();
        int          done_cnt;
        int          done_t [2];
        int          m;
        logic [31:0] cap_a;
        logic [31:0] cap_b;
        @(negedge clk);
        iPlainA  = 32'h0;
        iPlainB  = 32'h0;
        iStart   = 1'b1;
        done_cnt = 0;
        done_t[0] = -1;
        done_t[1] = -1;
        cap_a    = '0;
        cap_b    = '0;
        for (int n = 1; n <= 120; n++) begin
            @(negedge clk);
            if (oDone === 1'b1) begin
                if (done_cnt < 2) done_t[done_cnt] = n;
                done_cnt++;
                cap_a = oCipherA;
                cap_b = oCipherB;
            end
        end
        iStart = 1'b0;
        check_count++;
        if (done_cnt !== 2) $display("[TB] FAIL b2b_done_count: got %0d expected 2", done_cnt);
        else pass_count++;
        check_count++;
        if (done_t[0] !== 53) $display("[TB] FAIL b2b_first_done: got %0d expected 53", done_t[0]);
        else pass_count++;
        check_count++;
        if (done_t[1] - done_t[0] !== 54)
            $display("[TB] FAIL b2b_spacing: got %0d expected 54", done_t[1] - done_t[0]);
        else pass_count++;
        check_count++;
        if (cap_a !== KAT_A || cap_b !== KAT_B)
            $display("[TB] FAIL b2b_cipher: got %h/%h expected %h/%h", cap_a, cap_b, KAT_A, KAT_B);
        else pass_count++;
        m = 0;
        while (oDone !== 1'b1 && m < 100) begin
            @(negedge clk);
            m++;
        end
        check_count++;
        if (oDone !== 1'b1) $display("[TB] FAIL b2b_drain: got no done within %0d cycles", m);
        else pass_count++;
        @(negedge clk);
    endtask

`ifdef RC5_DECRYPT_EN
    task automatic test_decrypt();
        int lat;
        int busy;
        iDecrypt = 1'b1;
        run_op(KAT_A, KAT_B, lat, busy);
        iDecrypt = 1'b0;
        check_count++;
        if (first_addr !== T - 1) $display("[TB] FAIL dec_first_addr: got %0d expected %0d", first_addr, T - 1);
        else pass_count++;
        check_count++;
        if (lat !== 53) $display("[TB] FAIL dec_latency: got %0d expected 53", lat);
        else pass_count++;
        check_count++;
        if (oCipherA !== 32'h0 || oCipherB !== 32'h0)
            $display("[TB] FAIL dec_plain: got %h/%h expected 00000000/00000000", oCipherA, oCipherB);
        else pass_count++;
        check_count++;
        if (busy !== 52) $display("[TB] FAIL dec_busy_cycles: got %0d expected 52", busy);
        else pass_count++;
        @(negedge clk);
    endtask
`endif

    initial begin
        rst     = 1'b1;
        iStart  = 1'b0;
        iPlainA = '0;
        iPlainB = '0;
`ifdef RC5_DECRYPT_EN
        iDecrypt = 1'b0;
`endif
        clear_table();
        test_reset();
        test_null_table();
        test_known_answer();
        test_address_trace();
        test_reset_mid_op();
        test_ignored_start();
        test_back_to_back();
`ifdef RC5_DECRYPT_EN
        test_decrypt();
`endif
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
